adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 12-bit Brent-Kung adder (interleaved operand bus, 13-bit sum) among NUM_REQ requesters.
- Each requester presents an operand pair over a valid/ready handshake. The block grants one requester, drives the shared adder from registered operands, captures the sum, and returns it with the requester ID over a valid/ready response channel.
- Sits between client datapaths and the adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 12, operand width; must match the adder.
- IDW, 2, response ID width; equals clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a.
- add_in  out  2*WIDTH  to adder; add_in[2k]=A[k], add_in[2k+1]=B[k].
- add_sum  in  WIDTH+1  from adder; add_sum[WIDTH] is the carry out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_sum  out  WIDTH+1  registered sum.
- rsp_id  out  IDW  index of the requester that owns rsp_sum.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has top priority after reset), add_in=0, rsp_valid=0, rsp_sum=0, rsp_id=0. req_ready is forced 0 while rst_n=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Combinational grant g = first i with req_valid[i]=1, scanning from rr_ptr+1 upward modulo NUM_REQ.
  - req_ready[g]=1 only in IDLE; all other req_ready bits are 0.
  - On handshake (req_valid[g] & req_ready[g]): latch A, B and g into the operand/ID registers; rr_ptr<=g; next state EXEC.
  - No valid requests: stay in IDLE; add_in holds its last value.
- EXEC:
  - add_in is driven from the operand registers, interleaved.
  - At the end of the cycle: rsp_sum<=add_sum, rsp_id<=latched g, rsp_valid<=1; next state RESP.
  - Exactly one cycle; the adder path must close timing within it.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id are held stable until rsp_ready=1.
  - On rsp_ready: rsp_valid<=0 and next state IDLE.
  - All req_ready are 0 while in RESP.
- Latency and throughput:
  - Handshake at cycle T; rsp_valid first high at T+2.
  - Maximum throughput is one transaction per 3 cycles with rsp_ready held high.
- Arithmetic: unsigned, no carry-in. rsp_sum = A+B, WIDTH+1 bits, so carry is never lost (0xFFF+0xFFF=0x1FFE).
- Fairness:
  - A requester holding valid waits at most NUM_REQ-1 grants.
  - A granted requester moves to lowest priority next round.
- Requester protocol:
  - Requesters must hold req_valid and operands stable until accepted.
  - The block never drops an asserted request.
  - Deasserting req_valid before acceptance is permitted; arbitration then ignores that requester.
- Simultaneous events: a new request arriving in RESP waits; it is considered in the first IDLE cycle after the response handshake.
- Reset mid-operation: an in-flight transaction is discarded (no response); all state returns to reset values immediately.
- X-safety: add_in never depends on un-granted req_a/req_b.

Test Plan:
- Single request: requester 2 sends A=0x123, B=0x456, rsp_ready=1 → req_ready[2] high in IDLE cycle; 2 cycles later rsp_valid=1, rsp_sum=0x0579, rsp_id=2; add_in bit 0=1, bit 1=0 during EXEC.
- Carry out: A=0xFFF, B=0x001 → rsp_sum=0x1000. Also A=0xFFF, B=0xFFF → rsp_sum=0x1FFE.
- Round-robin: all 4 requesters valid continuously from reset → grant order 0,1,2,3,0; each response carries the matching rsp_id and sum; one grant per 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_sum/rsp_id stable and no req_ready asserted; on rsp_ready=1, return to IDLE and accept the next request the following cycle.
- Reset mid-transaction: assert rst_n=0 during EXEC → rsp_valid=0, rsp_sum=0, no response after release; next grant goes to requester 0 if valid.
- Withdrawn request: requester 1 valid then dropped before grant while requester 3 is valid → requester 3 granted; no response with id=1.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one external adder
// Grants one requester, drives the adder from registered operands, returns the sum.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 12,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [2*WIDTH-1:0]       add_in,
  input  logic [WIDTH:0]           add_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic [IDW-1:0]           rsp_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, gnt_idx, op_id;
  logic             gnt_found, accept;
  logic [WIDTH-1:0] op_a, op_b, gnt_a, gnt_b;

  // Two passes: requesters above rr_ptr first, then wrap around to the rest.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (i > int'(rr_ptr))) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (i <= int'(rr_ptr))) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
  end

  // Only the granted slice reaches the operand registers.
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_a = req_a[i*WIDTH +: WIDTH];
        gnt_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = (state == IDLE) && gnt_found && rst_n;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (gnt_idx == IDW'(i));
    end
  end

  always_comb begin
    add_in = '0;
    for (int k = 0; k < WIDTH; k++) begin
      add_in[2*k]   = op_a[k];
      add_in[2*k+1] = op_b[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IDW'(NUM_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        op_a   <= gnt_a;
        op_b   <= gnt_b;
        op_id  <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
      if (state == EXEC) begin
        rsp_sum   <= add_sum;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - randomized scoreboard bench for adder_share_arbiter
module tb_adder_share_arbiter;
  localparam int N   = 4;
  localparam int W   = 12;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [2*W-1:0]   add_in;
  logic [W:0]       add_sum;
  logic             rsp_valid, rsp_ready;
  logic [W:0]       rsp_sum;
  logic [IDW-1:0]   rsp_id;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_in(add_in), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id)
  );

  // Stand-in for the shared adder: de-interleave and add.
  logic [W-1:0] da, db;
  always_comb begin
    da = '0;
    db = '0;
    for (int k = 0; k < W; k++) begin
      da[k] = add_in[2*k];
      db[k] = add_in[2*k+1];
    end
    add_sum = {1'b0, da} + {1'b0, db};
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard state: one transaction outstanding at most.
  bit           busy = 1'b0;
  int           age = 0;
  int           last_g = N - 1;
  int           exp_id = 0;
  logic [W-1:0] exp_a = '0, exp_b = '0;
  logic [W:0]   exp_sum;
  logic [N-1:0] last_hs = '0;
  logic [N-1:0] m_er, m_hs;
  int           m_g;
  logic [2*W-1:0] exec_add_in = '0;
  int grant_log[$], grant_cyc[$], rsp_ids[$], rsp_sums[$], rsp_cyc[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [2*W-1:0] weave(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    for (int k = 0; k < W; k++) begin
      r[2*k]   = a[k];
      r[2*k+1] = b[k];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check(req_ready == '0, "reset_req_ready", req_ready, 0);
      check(rsp_valid == 1'b0, "reset_rsp_valid", rsp_valid, 0);
      check(rsp_sum == '0, "reset_rsp_sum", rsp_sum, 0);
      check(rsp_id == '0, "reset_rsp_id", rsp_id, 0);
      check(add_in == '0, "reset_add_in", add_in, 0);
      busy    = 1'b0;
      age     = 0;
      last_g  = N - 1;
      last_hs = '0;
    end else begin
      if (busy) age++;
      m_er = '0;
      m_g  = -1;
      if (!busy) begin
        m_g = rr_pick(req_valid, last_g);
        if (m_g >= 0) m_er[m_g] = 1'b1;
      end
      check(req_ready == m_er, "req_ready", req_ready, m_er);
      check(rsp_valid == (busy && age >= 2), "rsp_valid", rsp_valid, (busy && age >= 2));
      if (busy && age == 1) begin
        exec_add_in = add_in;
        check(add_in == weave(exp_a, exp_b), "add_in_exec", add_in, weave(exp_a, exp_b));
      end
      if (busy && age >= 2) begin
        exp_sum = {1'b0, exp_a} + {1'b0, exp_b};
        check(rsp_sum == exp_sum, "rsp_sum", rsp_sum, exp_sum);
        check(int'(rsp_id) == exp_id, "rsp_id", rsp_id, exp_id);
      end
      m_hs    = req_valid & req_ready;
      last_hs = m_hs;
      for (int i = 0; i < N; i++) begin
        if (m_hs[i]) begin
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
      if (busy && age >= 2 && rsp_ready) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_sums.push_back(int'(rsp_sum));
        rsp_cyc.push_back(cyc);
        busy = 1'b0;
      end else if (!busy && m_g >= 0) begin
        exp_id = m_g;
        exp_a  = req_a[m_g*W +: W];
        exp_b  = req_b[m_g*W +: W];
        busy   = 1'b1;
        age    = 0;
        last_g = m_g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid &= ~last_hs;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_rsp(input int n, input string what);
    int k = 0;
    while (rsp_ids.size() <= n && k < 60) begin
      tick();
      k++;
    end
    check(rsp_ids.size() > n, what, rsp_ids.size(), n + 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    check(!busy, "idle_timeout", busy, 0);
  endtask

  task automatic wait_rsp_valid();
    int k = 0;
    while (!rsp_valid && k < 60) begin
      tick();
      k++;
    end
    check(rsp_valid, "rsp_valid_timeout", rsp_valid, 1);
  endtask

  initial begin
    int n, ng, cnt, k;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 2.
    n = rsp_ids.size();
    set_req(2, 12'h123, 12'h456);
    wait_rsp(n, "single_timeout");
    check(rsp_ids[n] == 2, "single_id", rsp_ids[n], 2);
    check(rsp_sums[n] == 'h579, "single_sum", rsp_sums[n], 'h579);
    check(exec_add_in[1:0] == 2'b01, "single_add_in_lsbs", exec_add_in[1:0], 2'b01);
    check(rsp_cyc[n] - grant_cyc[grant_cyc.size()-1] == 2, "single_latency",
          rsp_cyc[n] - grant_cyc[grant_cyc.size()-1], 2);

    // Carry out.
    n = rsp_ids.size();
    set_req(0, 12'hFFF, 12'h001);
    wait_rsp(n, "carry1_timeout");
    check(rsp_sums[n] == 'h1000, "carry_fff_001", rsp_sums[n], 'h1000);
    n = rsp_ids.size();
    set_req(0, 12'hFFF, 12'hFFF);
    wait_rsp(n, "carry2_timeout");
    check(rsp_sums[n] == 'h1FFE, "carry_fff_fff", rsp_sums[n], 'h1FFE);

    // Round-robin from reset with every requester continuously valid.
    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom));
    rst_n = 1'b1;
    ng = grant_log.size();
    k  = 0;
    while (grant_log.size() < ng + 5 && k < 60) begin
      tick();
      for (int i = 0; i < N; i++) if (!req_valid[i]) set_req(i, W'($urandom), W'($urandom));
      k++;
    end
    check(grant_log.size() >= ng + 5, "rr_timeout", grant_log.size(), ng + 5);
    if (grant_log.size() >= ng + 5) begin
      for (int j = 0; j < 5; j++) begin
        check(grant_log[ng+j] == (j % N), "rr_order", grant_log[ng+j], j % N);
        if (j > 0)
          check(grant_cyc[ng+j] - grant_cyc[ng+j-1] == 3, "rr_spacing",
                grant_cyc[ng+j] - grant_cyc[ng+j-1], 3);
      end
    end
    req_valid = '0;
    wait_idle();

    // Backpressure on the response channel.
    rsp_ready = 1'b0;
    set_req(1, W'($urandom), W'($urandom));
    wait_rsp_valid();
    set_req(3, W'($urandom), W'($urandom));
    repeat (5) tick();
    n  = rsp_ids.size();
    ng = grant_log.size();
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();
    check(rsp_ids.size() > n && rsp_ids[n] == 1, "bp_rsp_id", rsp_ids.size() > n ? rsp_ids[n] : -1, 1);
    check(grant_log.size() > ng && grant_log[ng] == 3, "bp_next_grant",
          grant_log.size() > ng ? grant_log[ng] : -1, 3);
    if (rsp_ids.size() > n && grant_log.size() > ng)
      check(grant_cyc[ng] - rsp_cyc[n] == 1, "bp_regrant_gap", grant_cyc[ng] - rsp_cyc[n], 1);
    wait_idle();

    // Reset while the adder cycle is in flight.
    set_req(2, 12'h005, 12'h006);
    k = 0;
    while (!last_hs[2] && k < 40) begin
      tick();
      k++;
    end
    check(last_hs[2], "midrst_grant_timeout", last_hs, 4);
    rst_n = 1'b0;
    n = rsp_ids.size();
    tick();
    tick();
    set_req(0, 12'h010, 12'h020);
    set_req(2, 12'h030, 12'h040);
    rst_n = 1'b1;
    wait_rsp(n, "midrst_timeout");
    check(rsp_ids[n] == 0, "midrst_first_id", rsp_ids[n], 0);
    check(rsp_sums[n] == 'h030, "midrst_first_sum", rsp_sums[n], 'h030);
    wait_rsp(n + 1, "midrst2_timeout");
    wait_idle();

    // Withdrawn request: 1 drops out while the block is busy, 3 takes the grant.
    rsp_ready = 1'b0;
    set_req(0, W'($urandom), W'($urandom));
    wait_rsp_valid();
    set_req(1, 12'h111, 12'h111);
    tick();
    tick();
    req_valid[1] = 1'b0;
    set_req(3, 12'h300, 12'h033);
    tick();
    n  = rsp_ids.size();
    ng = grant_log.size();
    rsp_ready = 1'b1;
    wait_rsp(n + 1, "withdraw_timeout");
    check(grant_log.size() > ng && grant_log[ng] == 3, "withdraw_grant",
          grant_log.size() > ng ? grant_log[ng] : -1, 3);
    check(rsp_ids[n+1] == 3, "withdraw_rsp_id", rsp_ids[n+1], 3);
    check(rsp_sums[n+1] == 'h333, "withdraw_rsp_sum", rsp_sums[n+1], 'h333);
    cnt = 0;
    for (int j = n; j < rsp_ids.size(); j++) if (rsp_ids[j] == 1) cnt++;
    check(cnt == 0, "withdraw_no_id1", cnt, 0);
    wait_idle();

    // Random traffic, withdrawals and backpressure.
    n = rsp_ids.size();
    for (int c = 0; c < 500; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 4 == 0)) set_req(i, W'($urandom), W'($urandom));
        else if (req_valid[i] && ($urandom % 24 == 0)) req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom % 3 != 0);
    end
    check(rsp_ids.size() > n + 20, "random_progress", rsp_ids.size() - n, 21);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
